// File: rtl/alu_shift_add_mul.sv
// Sequential shift-add unsigned multiplier feeding an external CLA adder.
// One conditional add plus right shift per cycle; WIDTH must be a multiple of 4.
module alu_shift_add_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  output logic               add_cin,
  input  logic [WIDTH-1:0]   add_sum,
  input  logic               add_cout
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t             state;
  state_t             state_n;
  logic [WIDTH-1:0]   m;
  logic [WIDTH-1:0]   m_n;
  logic [2*WIDTH-1:0] p;
  logic [2*WIDTH-1:0] p_n;
  logic [2*WIDTH-1:0] step;
  logic [2*WIDTH-1:0] product_n;
  logic [CW-1:0]      cnt;
  logic [CW-1:0]      cnt_n;
  logic               done_n;

  assign busy    = (state == RUN);
  assign add_a   = p[2*WIDTH-1:WIDTH];
  assign add_b   = p[0] ? m : '0;
  assign add_cin = 1'b0;

  // Carry-out lands in the MSB so the shifted sum never loses a bit.
  assign step = {add_cout, add_sum, p[WIDTH-1:1]};

  always_comb begin
    state_n   = state;
    m_n       = m;
    p_n       = p;
    cnt_n     = cnt;
    product_n = product;
    done_n    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          m_n     = a;
          p_n     = {{WIDTH{1'b0}}, b};
          cnt_n   = '0;
          state_n = RUN;
        end
      end
      RUN: begin
        p_n   = step;
        cnt_n = cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          product_n = step;
          done_n    = 1'b1;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      m       <= '0;
      p       <= '0;
      cnt     <= '0;
      product <= '0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      m       <= m_n;
      p       <= p_n;
      cnt     <= cnt_n;
      product <= product_n;
      done    <= done_n;
    end
  end

endmodule
